// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with hold-time preemption and a one-cycle gap between owners
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] OWNER,
    output logic       BUSY,
    output logic       PREEMPT
);
    localparam logic [7:0] LIM = 8'(MAX_HOLD);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t     state, state_n;
    logic [1:0] ptr, ptr_n, owner_n, win;
    logic [7:0] hold, hold_n;
    logic       found, others, timeout, release_now, preempt_n;
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            hold    <= 8'd0;
            OWNER   <= 2'd0;
            PREEMPT <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            hold    <= hold_n;
            OWNER   <= owner_n;
            PREEMPT <= preempt_n;
        end
    end
    // scan downward so the request closest to ptr is the last (winning) assignment
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end
    always_comb begin
        others      = |(REQ & ~(4'b0001 << OWNER));
        timeout     = (LIM != 8'd0) && (hold >= LIM) && others;
        release_now = !REQ[OWNER];
        state_n     = (state == GRANT) ? ((release_now || timeout) ? GAP : GRANT)
                                       : (found ? GRANT : IDLE);
        ptr_n       = (state == GRANT && state_n == GAP) ? OWNER + 2'd1 : ptr;
        owner_n     = (state != GRANT && found) ? win : OWNER;
        hold_n      = (state != GRANT) ? (found ? 8'd1 : hold)
                                       : ((hold == 8'd255) ? hold : hold + 8'd1);
        preempt_n   = (state == GRANT) && !release_now && timeout;
    end
    always_comb begin
        BUSY = (state == GRANT);
        GNT  = BUSY ? (4'b0001 << OWNER) : 4'b0000;
    end
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed and random checks of rr_arb4 (MAX_HOLD 4 and 0) against a behavioural model
module tb_rr_arb4;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt [2];
    logic [1:0] owner [2];
    logic       busy [2];
    logic       pre [2];
    int         checks = 0;
    int         errors = 0;
    bit         armed = 1'b0;
    int         mh [2] = '{4, 0};
    int         m_owner [2];
    int         m_ptr [2];
    int         m_hold [2];
    bit         m_busy [2];
    bit         m_pre [2];

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(4)) u0 (
        .CLK(clk), .RSTN(rstn), .REQ(req),
        .GNT(gnt[0]), .OWNER(owner[0]), .BUSY(busy[0]), .PREEMPT(pre[0])
    );
    rr_arb4 #(.MAX_HOLD(0)) u1 (
        .CLK(clk), .RSTN(rstn), .REQ(req),
        .GNT(gnt[1]), .OWNER(owner[1]), .BUSY(busy[1]), .PREEMPT(pre[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Idle and the post-release dead cycle behave alike: both arbitrate at their closing edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_owner[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_busy[i] = 0; m_pre[i] = 0;
            end else if (m_busy[i]) begin
                m_pre[i] = 0;
                if (!req[m_owner[i]]) begin
                    m_busy[i] = 0;
                    m_ptr[i] = (m_owner[i] + 1) % 4;
                end else if (mh[i] != 0 && m_hold[i] >= mh[i] && (req & ~(4'b0001 << m_owner[i])) != 0) begin
                    m_busy[i] = 0;
                    m_pre[i] = 1;
                    m_ptr[i] = (m_owner[i] + 1) % 4;
                end else begin
                    m_hold[i] = (m_hold[i] < 255) ? m_hold[i] + 1 : 255;
                end
            end else begin
                m_pre[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr[i] + k) % 4]) begin
                        m_owner[i] = (m_ptr[i] + k) % 4;
                        m_busy[i] = 1;
                        m_hold[i] = 1;
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("gnt%0d", i), int'(gnt[i]), m_busy[i] ? (1 << m_owner[i]) : 0);
                chk($sformatf("owner%0d", i), int'(owner[i]), m_owner[i]);
                chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_busy[i]));
                chk($sformatf("preempt%0d", i), int'(pre[i]), int'(m_pre[i]));
                chk($sformatf("onehot%0d", i), int'($countones(gnt[i]) <= 1), 1);
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("reset_gnt", int'(gnt[0]), 0);
        chk("reset_owner", int'(owner[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_preempt", int'(pre[0]), 0);
        // request latency and release gap
        rstn = 1'b1;
        req = 4'b0101;
        @(negedge clk);
        chk("first_grant", int'(gnt[0]), 4'b0001);
        req = 4'b0100;
        @(negedge clk);
        chk("release_gap", int'(gnt[0]), 4'b0000);
        @(negedge clk);
        chk("after_gap", int'(gnt[0]), 4'b0100);
        // full contention rotation with preemption
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("rotate_gnt", int'(gnt[0]), 1 << (g % 4));
                chk("nohold_gnt", int'(gnt[1]), 4'b0001);
            end
            @(negedge clk);
            if (g < 4) begin
                chk("rotate_gap", int'(gnt[0]), 0);
                chk("rotate_pulse", int'(pre[0]), 1);
            end
        end
        // sole requester is never preempted
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("sole_gnt", int'(gnt[0]), 4'b0100);
            chk("sole_nopre", int'(pre[0]), 0);
        end
        req = 4'b1100;
        @(negedge clk);
        chk("late_pre_gnt", int'(gnt[0]), 0);
        chk("late_pre_pulse", int'(pre[0]), 1);
        @(negedge clk);
        chk("late_pre_next", int'(gnt[0]), 4'b1000);
        // preemption disabled
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("nopre_gnt", int'(gnt[1]), 4'b0001);
            chk("nopre_pulse", int'(pre[1]), 0);
        end
        // pointer wraps from 3 to 0
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        chk("own3_gnt", int'(gnt[0]), 4'b1000);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_gnt", int'(gnt[0]), 4'b0001);
        // reset in the middle of a grant
        do_reset();
        req = 4'b0110;
        @(negedge clk);
        chk("pre_rst_gnt", int'(gnt[0]), 4'b0010);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", int'(gnt[0]), 0);
        chk("midrst_owner", int'(owner[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_pre", int'(pre[0]), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", int'(gnt[0]), 4'b0010);
        // random traffic with sticky request levels
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) req[b] = ~req[b];
            rstn = ($urandom_range(149) != 0);
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
